// File: rtl/pc_sequencer.sv
// MIPS program-counter sequencer: RUN/DELAY/HALTED state machine with one branch-delay slot,
// fetch stall, sticky halt and link-address output. Define PC_ALIGN_CHECK_EN to trap misaligned JR/JALR targets.
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              stall,
  input  logic [6:0]        instruction_code,
  input  logic [15:0]       offset,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] register_data,
  input  logic              zero,
  input  logic              positive,
  input  logic              negative,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] link_address,
  output logic              delay_slot,
  output logic              pc_halt,
  output logic              align_fault,
  output logic [1:0]        state_dbg
);

  localparam logic [6:0] OP_BEQ    = 7'd30;
  localparam logic [6:0] OP_BGEZ   = 7'd31;
  localparam logic [6:0] OP_BGEZAL = 7'd32;
  localparam logic [6:0] OP_BGTZ   = 7'd33;
  localparam logic [6:0] OP_BLEZ   = 7'd34;
  localparam logic [6:0] OP_BLTZ   = 7'd35;
  localparam logic [6:0] OP_BLTZAL = 7'd36;
  localparam logic [6:0] OP_BNE    = 7'd37;
  localparam logic [6:0] OP_J      = 7'd38;
  localparam logic [6:0] OP_JAL    = 7'd39;
  localparam logic [6:0] OP_JALR   = 7'd40;
  localparam logic [6:0] OP_JR     = 7'd41;

  localparam logic [ADDR_W-1:0] RST_PC   = RESET_VECTOR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] HALT_PC  = HALT_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] LINK_OFS = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DELAY  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] address_n;
  logic [ADDR_W-1:0] target_reg, target_n;
  logic [ADDR_W-1:0] br_tgt, j_tgt, reg_tgt, target;
  logic [ADDR_W-1:0] seq_pc;
  logic              accept;
  logic              taken;
  logic              is_reg_jump;
  logic              reg_misaligned;
  logic              fault_set;

  // Handshake: fetch is a one-cycle strobe with no back-pressure of its own; a fetch is
  // accepted only when stall is low, and every register holds on any cycle without an accepted fetch.
  assign accept = fetch & ~stall;

  assign seq_pc       = address + PC_STEP;
  assign br_tgt       = seq_pc + {{(ADDR_W-18){offset[15]}}, offset, 2'b00};
  assign link_address = address + LINK_OFS;
  assign delay_slot   = (state == ST_DELAY);
  assign pc_halt      = (address == HALT_PC) || (state == ST_HALTED);
  assign state_dbg    = state;

  // J/JAL keep whatever segment bits lie above the 28-bit jump field.
  generate
    if (ADDR_W > 28) begin : g_jseg
      assign j_tgt = {address[ADDR_W-1:28], instr_index, 2'b00};
    end else begin : g_jnoseg
      assign j_tgt = {instr_index, 2'b00};
    end
  endgenerate

  assign is_reg_jump    = (instruction_code == OP_JR) || (instruction_code == OP_JALR);
  assign reg_misaligned = |(register_data & LOW_MASK);

`ifdef PC_ALIGN_CHECK_EN
  assign reg_tgt   = register_data;
  assign fault_set = is_reg_jump & reg_misaligned;
`else
  assign reg_tgt   = register_data & ~LOW_MASK;
  assign fault_set = 1'b0;
`endif

  always_comb begin
    taken  = 1'b0;
    target = br_tgt;
    case (instruction_code)
      OP_BEQ:              taken = zero;
      OP_BNE:              taken = positive | negative;
      OP_BGTZ:             taken = positive;
      OP_BLEZ:             taken = zero | negative;
      OP_BGEZ, OP_BGEZAL:  taken = positive | zero;
      OP_BLTZ, OP_BLTZAL:  taken = negative;
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = j_tgt;
      end
      OP_JR, OP_JALR: begin
        taken  = ~fault_set;
        target = reg_tgt;
      end
      default:             taken = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    address_n = address;
    target_n  = target_reg;
    if (accept) begin
      case (state)
        ST_RUN: begin
          if (pc_halt) begin
            address_n = HALT_PC;
            state_n   = ST_HALTED;
          end else begin
            address_n = seq_pc;
            if (taken) begin
              target_n = target;
              state_n  = ST_DELAY;
            end
          end
        end
        // Delay slot: control codes here are ignored; a halt address still wins.
        ST_DELAY: begin
          if (pc_halt) begin
            address_n = HALT_PC;
            state_n   = ST_HALTED;
          end else begin
            address_n = target_reg;
            state_n   = ST_RUN;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      address    <= RST_PC;
      target_reg <= '0;
    end else begin
      state      <= state_n;
      address    <= address_n;
      target_reg <= target_n;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (accept && state == ST_RUN && !pc_halt && fault_set) begin
      fault_q <= 1'b1;
    end
  end

  assign align_fault = fault_q;
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters: reset vector BFC00000, halt address 0).
module tb_pc_sequencer;

  localparam logic [6:0] OP_NONE = 7'd0;
  localparam logic [6:0] OP_BEQ  = 7'd30;
  localparam logic [6:0] OP_BGEZ = 7'd31;
  localparam logic [6:0] OP_BGTZ = 7'd33;
  localparam logic [6:0] OP_BLTZ = 7'd35;
  localparam logic [6:0] OP_BNE  = 7'd37;
  localparam logic [6:0] OP_J    = 7'd38;
  localparam logic [6:0] OP_JR   = 7'd41;

  localparam logic [31:0] S_RUN    = 32'd0;
  localparam logic [31:0] S_DELAY  = 32'd1;
  localparam logic [31:0] S_HALTED = 32'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch;
  logic        stall;
  logic [6:0]  instruction_code;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] register_data;
  logic        zero, positive, negative;
  logic [31:0] address;
  logic [31:0] link_address;
  logic        delay_slot;
  logic        pc_halt;
  logic        align_fault;
  logic [1:0]  state_dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .fetch            (fetch),
    .stall            (stall),
    .instruction_code (instruction_code),
    .offset           (offset),
    .instr_index      (instr_index),
    .register_data    (register_data),
    .zero             (zero),
    .positive         (positive),
    .negative         (negative),
    .address          (address),
    .link_address     (link_address),
    .delay_slot       (delay_slot),
    .pc_halt          (pc_halt),
    .align_fault      (align_fault),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_ctl(input logic [6:0] c, input logic [15:0] off, input logic [25:0] idx,
                         input logic [31:0] rd, input logic z, input logic p, input logic n);
    instruction_code = c;
    offset           = off;
    instr_index      = idx;
    register_data    = rd;
    zero             = z;
    positive         = p;
    negative         = n;
  endtask

  task automatic clr_ctl();
    set_ctl(OP_NONE, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock with the given strobes; outputs are sampled 1ns after the edge.
  task automatic step(input logic f, input logic s);
    fetch = f;
    stall = s;
    @(posedge clk);
    #1;
    fetch = 1'b0;
    stall = 1'b0;
  endtask

  task automatic do_reset();
    clr_ctl();
    fetch = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    fetch = 1'b0;
    stall = 1'b0;
    clr_ctl();
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", address, 32'hBFC00000);
    check("rst_state", 32'(state_dbg), S_RUN);
    check("rst_delay", 32'(delay_slot), 32'd0);
    check("rst_halt", 32'(pc_halt), 32'd0);
    check("rst_fault", 32'(align_fault), 32'd0);
    check("rst_link", link_address, 32'hBFC00008);
    reset = 1'b0;

    // Sequential fetches
    exp_q.push_back(32'hBFC00004);
    exp_q.push_back(32'hBFC00008);
    exp_q.push_back(32'hBFC0000C);
    repeat (3) begin
      step(1'b1, 1'b0);
      check("seq_addr", address, exp_q.pop_front());
    end
    check("seq_delay", 32'(delay_slot), 32'd0);
    step(1'b1, 1'b1);
    check("run_stall_hold", address, 32'hBFC0000C);
    step(1'b0, 1'b0);
    check("no_fetch_hold", address, 32'hBFC0000C);

    // Taken BEQ, offset 3: target BFC00000+4+12
    do_reset();
    set_ctl(OP_BEQ, 16'd3, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("beq_link", link_address, 32'hBFC00008);
    step(1'b1, 1'b0);
    check("beq_slot_addr", address, 32'hBFC00004);
    check("beq_slot_flag", 32'(delay_slot), 32'd1);
    clr_ctl();
    step(1'b1, 1'b0);
    check("beq_target", address, 32'hBFC00010);
    check("beq_back_run", 32'(delay_slot), 32'd0);

    // BNE not taken on zero; J inside a delay slot is ignored
    do_reset();
    set_ctl(OP_BNE, 16'd3, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("bne_nt_addr", address, 32'hBFC00004);
    check("bne_nt_delay", 32'(delay_slot), 32'd0);
    set_ctl(OP_BEQ, 16'd3, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("beq2_slot", address, 32'hBFC00008);
    set_ctl(OP_J, 16'h0, 26'h0000040, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("j_in_slot_ignored", address, 32'hBFC00014);
    check("j_in_slot_state", 32'(state_dbg), S_RUN);
    // J from BFC00014: segment B, index 0x40 -> B0000100
    step(1'b1, 1'b0);
    check("j_slot", address, 32'hBFC00018);
    clr_ctl();
    step(1'b1, 1'b0);
    check("j_target", address, 32'hB0000100);

    // Negative offset BLTZ, then BGEZ not taken on negative
    do_reset();
    set_ctl(OP_BLTZ, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    clr_ctl();
    step(1'b1, 1'b0);
    check("bltz_back_target", address, 32'hBFBFFFFC);
    set_ctl(OP_BGEZ, 16'h0010, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("bgez_nt", address, 32'hBFC00000);
    check("bgez_nt_delay", 32'(delay_slot), 32'd0);

    // JR to 0 from BFC00020: delay slot, halt address, then HALTED
    do_reset();
    repeat (8) step(1'b1, 1'b0);
    check("walk_to_20", address, 32'hBFC00020);
    set_ctl(OP_JR, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("jr0_slot", address, 32'hBFC00024);
    clr_ctl();
    step(1'b1, 1'b0);
    check("jr0_addr", address, 32'h00000000);
    check("jr0_halt_flag", 32'(pc_halt), 32'd1);
    check("jr0_state_run", 32'(state_dbg), S_RUN);
    step(1'b1, 1'b0);
    check("halted_state", 32'(state_dbg), S_HALTED);
    set_ctl(OP_JR, 16'h0, 26'h0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    check("halted_addr_hold", address, 32'h00000000);
    check("halted_sticky", 32'(state_dbg), S_HALTED);
    check("halted_pc_halt", 32'(pc_halt), 32'd1);

    // Stall in DELAY, then async reset mid-DELAY
    do_reset();
    set_ctl(OP_BGTZ, 16'd8, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    clr_ctl();
    repeat (5) step(1'b1, 1'b1);
    check("stall_addr_hold", address, 32'hBFC00004);
    check("stall_delay_hold", 32'(delay_slot), 32'd1);
    step(1'b1, 1'b0);
    check("stall_release_target", address, 32'hBFC00024);
    check("stall_release_state", 32'(state_dbg), S_RUN);
    set_ctl(OP_BEQ, 16'd1, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("pre_rst_delay", 32'(delay_slot), 32'd1);
    clr_ctl();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_addr", address, 32'hBFC00000);
    check("async_rst_state", 32'(state_dbg), S_RUN);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0);
    check("target_discarded", address, 32'hBFC00004);

    // Wrap FFFFFFFC -> 0, which then halts
    do_reset();
    set_ctl(OP_JR, 16'h0, 26'h0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    clr_ctl();
    step(1'b1, 1'b0);
    check("wrap_top", address, 32'hFFFFFFFC);
    check("wrap_link", link_address, 32'h00000004);
    step(1'b1, 1'b0);
    check("wrap_zero", address, 32'h00000000);
    check("wrap_pc_halt", 32'(pc_halt), 32'd1);
    step(1'b1, 1'b0);
    check("wrap_halted", 32'(state_dbg), S_HALTED);

    // Misaligned register jump
    do_reset();
    set_ctl(OP_JR, 16'h0, 26'h0, 32'hBFC00102, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("mis_first", address, 32'hBFC00004);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_fault", 32'(align_fault), 32'd1);
    check("mis_no_delay", 32'(delay_slot), 32'd0);
    clr_ctl();
    step(1'b1, 1'b0);
    check("mis_seq", address, 32'hBFC00008);
    check("mis_fault_sticky", 32'(align_fault), 32'd1);
`else
    check("mis_fault_tied", 32'(align_fault), 32'd0);
    check("mis_delay", 32'(delay_slot), 32'd1);
    clr_ctl();
    step(1'b1, 1'b0);
    check("mis_forced_align", address, 32'hBFC00100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
